// File: rtl/vp_controller_pkg.sv
// Shared types for the load value-prediction controller.
// Also provides fallback `ADDR_WIDTH / `DATA_WIDTH when the core does not define them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package vp_controller_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    RECOVER
  } vp_state_e;

  localparam int unsigned VP_INDEX_WIDTH = 6;

endpackage

// File: rtl/vp_controller_conf_table.sv
// Per-PC saturating confidence counters: combinational read, increment/clear write,
// all entries cleared by reset.
module vp_conf_table
  import vp_controller_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = VP_INDEX_WIDTH,
  parameter int unsigned CONF_BITS   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output logic [CONF_BITS-1:0]   rd_cnt,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic                   wr_inc
);

  localparam int unsigned ENTRIES = 1 << INDEX_WIDTH;
  localparam logic [CONF_BITS-1:0] CNT_MAX = '1;

  logic [CONF_BITS-1:0] cnt_q [ENTRIES];
  logic [CONF_BITS-1:0] cnt_d [ENTRIES];

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) begin
      if (!wr_inc) begin
        cnt_d[wr_idx] = '0;
      end else if (cnt_q[wr_idx] != CNT_MAX) begin
        cnt_d[wr_idx] = cnt_q[wr_idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/vp_controller.sv
// Load value-prediction sequencer: forwards predictions, tracks one outstanding load,
// drives squash/recovery on mispredict. Confidence gating built only with VP_CONF_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module vp_controller
  import vp_controller_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = VP_INDEX_WIDTH,
  parameter int unsigned CONF_BITS   = 2,
  parameter int unsigned CONF_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_issue,
  input  logic [`ADDR_WIDTH-1:0] ld_pc,
  input  logic [`DATA_WIDTH-1:0] ld_pred,
  input  logic                   mem_valid,
  input  logic [`DATA_WIDTH-1:0] mem_data,
  input  logic                   recovery_done,
  output logic                   pred_use,
  output logic [`DATA_WIDTH-1:0] pred_value,
  output logic                   stall_issue,
  output logic                   flush,
  output logic [`ADDR_WIDTH-1:0] flush_pc,
  output logic [`DATA_WIDTH-1:0] corr_value,
  output logic                   commit,
  output logic                   recovery_ack
);

  vp_state_e              state_q, state_d;
  logic [`ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [`DATA_WIDTH-1:0] pred_q, pred_d;
  logic [`DATA_WIDTH-1:0] corr_q, corr_d;
  logic                   predicted_q, predicted_d;
  logic                   pred_use_q, pred_use_d;
  logic                   commit_q, commit_d;
  logic                   ack_q, ack_d;
  logic                   issue_pred;
  logic                   tbl_wr_en;
  logic                   tbl_inc;

`ifdef VP_CONF_EN
  localparam logic [CONF_BITS-1:0] THRESH = CONF_BITS'(CONF_THRESH);

  logic [INDEX_WIDTH-1:0] rd_idx;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [CONF_BITS-1:0]   rd_cnt;

  assign rd_idx     = ld_pc[INDEX_WIDTH+1:2];
  assign issue_pred = (rd_cnt >= THRESH);

  always_comb begin
    idx_d = idx_q;
    if (state_q == IDLE && ld_issue) begin
      idx_d = rd_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  vp_conf_table #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .CONF_BITS   (CONF_BITS)
  ) u_conf_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_idx (rd_idx),
    .rd_cnt (rd_cnt),
    .wr_en  (tbl_wr_en),
    .wr_idx (idx_q),
    .wr_inc (tbl_inc)
  );
`else
  // Without the table every load is predicted; the training strobes have no sink.
  logic unused_cfg;
  assign issue_pred = 1'b1;
  assign unused_cfg = ^{tbl_wr_en, tbl_inc, (CONF_BITS != 0), (CONF_THRESH != 0),
                        (INDEX_WIDTH != 0)};
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pred_d      = pred_q;
    corr_d      = corr_q;
    predicted_d = predicted_q;
    pred_use_d  = 1'b0;
    commit_d    = 1'b0;
    ack_d       = 1'b0;
    tbl_wr_en   = 1'b0;
    tbl_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_issue) begin
          pc_d        = ld_pc;
          pred_d      = ld_pred;
          predicted_d = issue_pred;
          pred_use_d  = issue_pred;
          state_d     = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (mem_valid) begin
          tbl_wr_en = 1'b1;
          if (mem_data == pred_q) begin
            tbl_inc  = 1'b1;
            commit_d = predicted_q;
            state_d  = IDLE;
          end else if (predicted_q) begin
            corr_d  = mem_data;
            state_d = RECOVER;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RECOVER: begin
        if (recovery_done) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      pred_q      <= '0;
      corr_q      <= '0;
      predicted_q <= 1'b0;
      pred_use_q  <= 1'b0;
      commit_q    <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pred_q      <= pred_d;
      corr_q      <= corr_d;
      predicted_q <= predicted_d;
      pred_use_q  <= pred_use_d;
      commit_q    <= commit_d;
      ack_q       <= ack_d;
    end
  end

  assign pred_use     = pred_use_q;
  assign pred_value   = pred_q;
  assign stall_issue  = (state_q != IDLE);
  assign flush        = (state_q == RECOVER);
  assign flush_pc     = pc_q;
  assign corr_value   = corr_q;
  assign commit       = commit_q;
  assign recovery_ack = ack_q;

endmodule

// File: tb/tb_vp_controller.sv
// Bench for vp_controller: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a transaction-level model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_vp_controller;

  localparam int AW   = `ADDR_WIDTH;
  localparam int DW   = `DATA_WIDTH;
  localparam int NENT = 64;
  localparam int CMAX = 3;
  localparam int THR  = 2;
`ifdef VP_CONF_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_issue = 1'b0;
  logic [AW-1:0] ld_pc = '0;
  logic [DW-1:0] ld_pred = '0;
  logic          mem_valid = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic          recovery_done = 1'b0;
  logic          pred_use, stall_issue, flush, commit, recovery_ack;
  logic [DW-1:0] pred_value, corr_value;
  logic [AW-1:0] flush_pc;

  vp_controller #(
    .INDEX_WIDTH (6),
    .CONF_BITS   (2),
    .CONF_THRESH (THR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_issue      (ld_issue),
    .ld_pc         (ld_pc),
    .ld_pred       (ld_pred),
    .mem_valid     (mem_valid),
    .mem_data      (mem_data),
    .recovery_done (recovery_done),
    .pred_use      (pred_use),
    .pred_value    (pred_value),
    .stall_issue   (stall_issue),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .corr_value    (corr_value),
    .commit        (commit),
    .recovery_ack  (recovery_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: one optional outstanding load, a recovery flag, and a counter per index.
  int            conf [NENT];
  bit            busy, recov, p_pred;
  int            p_idx;
  logic [AW-1:0] p_pc, e_flush_pc;
  logic [DW-1:0] p_val, e_pred_value, e_corr;
  bit            e_pred_use, e_commit, e_ack;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        foreach (conf[i]) conf[i] = 0;
        busy = 0; recov = 0; e_pred_use = 0; e_commit = 0; e_ack = 0;
      end else begin
        e_pred_use = 0; e_commit = 0; e_ack = 0;
        if (recov) begin
          if (recovery_done) begin
            recov = 0;
            e_ack = 1;
          end
        end else if (busy) begin
          if (mem_valid) begin
            busy = 0;
            if (mem_data == p_val) begin
              conf[p_idx] = (conf[p_idx] < CMAX) ? conf[p_idx] + 1 : CMAX;
              e_commit = p_pred;
            end else begin
              conf[p_idx] = 0;
              if (p_pred) begin
                recov = 1;
                e_flush_pc = p_pc;
                e_corr = mem_data;
              end
            end
          end
        end else if (ld_issue) begin
          p_idx  = int'((ld_pc >> 2) % NENT);
          p_pred = !CONF_EN || (conf[p_idx] >= THR);
          p_pc   = ld_pc;
          p_val  = ld_pred;
          busy   = 1;
          e_pred_use   = p_pred;
          e_pred_value = ld_pred;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("stall_issue", 64'(stall_issue), 64'(busy || recov));
    check("flush", 64'(flush), 64'(recov));
    check("pred_use", 64'(pred_use), 64'(e_pred_use));
    check("commit", 64'(commit), 64'(e_commit));
    check("recovery_ack", 64'(recovery_ack), 64'(e_ack));
    if (e_pred_use) check("pred_value", 64'(pred_value), 64'(e_pred_value));
    if (recov) begin
      check("flush_pc", 64'(flush_pc), 64'(e_flush_pc));
      check("corr_value", 64'(corr_value), 64'(e_corr));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [AW-1:0] pc, input logic [DW-1:0] pv);
    ld_issue = 1'b1; ld_pc = pc; ld_pred = pv;
    step();
    ld_issue = 1'b0;
  endtask

  task automatic respond(input logic [DW-1:0] d);
    mem_valid = 1'b1; mem_data = d;
    step();
    mem_valid = 1'b0;
  endtask

  logic [DW-1:0] last_pred = '0;

  initial begin
    repeat (3) step();
    check("rst_pred_use", 64'(pred_use), 64'd0);
    check("rst_stall", 64'(stall_issue), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_pred_value", 64'(pred_value), 64'd0);
    check("rst_flush_pc", 64'(flush_pc), 64'd0);
    check("rst_corr", 64'(corr_value), 64'd0);
    rst_n = 1'b1;
    step();

    // Training at PC 0x100: third issue is the first predicted one when gated.
    for (int k = 0; k < 3; k++) begin
      issue(32'h100, 32'h0);
      check("train_pred_use", 64'(pred_use), 64'((k == 2) || !CONF_EN));
      check("train_stall", 64'(stall_issue), 64'd1);
      if (k == 2) check("train_pred_value", 64'(pred_value), 64'h0);
      respond(32'h0);
      check("train_commit", 64'(commit), 64'((k == 2) || !CONF_EN));
    end

    // Mispredict, with issue/mem_valid noise ignored during recovery.
    issue(32'h100, 32'h0);
    check("mis_pred_use", 64'(pred_use), 64'd1);
    respond(32'h5);
    check("mis_flush", 64'(flush), 64'd1);
    check("mis_flush_pc", 64'(flush_pc), 64'h100);
    check("mis_corr", 64'(corr_value), 64'h5);
    ld_issue = 1'b1; ld_pc = 32'h300; ld_pred = 32'h1; mem_valid = 1'b1; mem_data = 32'h9;
    repeat (3) step();
    check("rec_hold_flush", 64'(flush), 64'd1);
    check("rec_hold_pc", 64'(flush_pc), 64'h100);
    ld_issue = 1'b0; mem_valid = 1'b0; recovery_done = 1'b1;
    step();
    recovery_done = 1'b0;
    check("rec_ack", 64'(recovery_ack), 64'd1);
    check("rec_flush_low", 64'(flush), 64'd0);
    check("rec_stall_low", 64'(stall_issue), 64'd0);
    step();
    check("rec_ack_pulse", 64'(recovery_ack), 64'd0);
    issue(32'h100, 32'h0);
    check("cleared_pred_use", 64'(pred_use), 64'(!CONF_EN));
    respond(32'h0);

    // Back-to-back issues while busy: only the first (pred 9) is latched.
    ld_issue = 1'b1; ld_pc = 32'h104; ld_pred = 32'h9;
    step();
    ld_pred = 32'h7;
    repeat (2) step();
    check("busy_stall", 64'(stall_issue), 64'd1);
    mem_valid = 1'b1; mem_data = 32'h9;
    step();
    ld_issue = 1'b0; mem_valid = 1'b0;
    check("busy_commit", 64'(commit), 64'(!CONF_EN));
    check("busy_flush", 64'(flush), 64'd0);

    // mem_valid alongside an IDLE issue must not resolve it.
    ld_issue = 1'b1; ld_pc = 32'h108; ld_pred = 32'h3; mem_valid = 1'b1; mem_data = 32'h4;
    step();
    ld_issue = 1'b0; mem_valid = 1'b0;
    step();
    check("early_mv_stall", 64'(stall_issue), 64'd1);
    respond(32'h3);
    check("late_mv_stall", 64'(stall_issue), 64'd0);
    check("late_mv_commit", 64'(commit), 64'(!CONF_EN));

    // Asynchronous reset while recovering.
    for (int k = 0; k < 3; k++) begin
      issue(32'h200, 32'h1);
      respond(32'h1);
    end
    issue(32'h200, 32'h1);
    respond(32'h2);
    check("pre_rst_flush", 64'(flush), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_flush_drop", 64'(flush), 64'd0);
    check("async_stall_drop", 64'(stall_issue), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    issue(32'h200, 32'h1);
    check("post_rst_pred_use", 64'(pred_use), 64'(!CONF_EN));
    respond(32'h1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      ld_issue = ($urandom_range(0, 1) == 1);
      ld_pc    = AW'(32'h1000 + ($urandom_range(0, 7) << 2));
      ld_pred  = DW'($urandom_range(0, 1));
      if (ld_issue) last_pred = ld_pred;
      mem_valid     = ($urandom_range(0, 1) == 1);
      mem_data      = ($urandom_range(0, 3) != 0) ? last_pred : DW'($urandom_range(0, 1));
      recovery_done = ($urandom_range(0, 9) < 3);
      step();
    end
    ld_issue = 1'b0; mem_valid = 1'b0; recovery_done = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
